// File: rtl/qam_symbol_source_if.sv
`default_nettype none
// ============================================================================
// Module      : qam_symbol_source_if
// Description : External serial bit stream (valid/ready) into the symbol source.
// Revision    : 1.0 - initial release
// ============================================================================
interface qam_symbol_source_if;
  logic ext_bit;
  logic ext_valid;
  logic ext_ready;

  modport master (
    output ext_bit,
    output ext_valid,
    input  ext_ready
  );

  modport slave (
    input  ext_bit,
    input  ext_valid,
    output ext_ready
  );
endinterface
`default_nettype wire

// File: rtl/qam_symbol_source.sv
`default_nettype none
// ============================================================================
// Module      : qam_symbol_source
// Description : Packs PRBS-7 or external serial bits into I/Q sign pairs and
//               holds each pair for SAMPLES_PER_SYMBOL sample strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module qam_symbol_source #(
  parameter int         SAMPLES_PER_SYMBOL = 64,
  parameter logic [6:0] PRBS_SEED          = 7'h7F
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               src_sel,
  qam_symbol_source_if.slave ext,
  output logic               elojel_sin,
  output logic               elojel_cos,
  output logic               sym_strobe,
  output logic               underrun
);

  localparam int c_cnt_w = (SAMPLES_PER_SYMBOL > 1) ? $clog2(SAMPLES_PER_SYMBOL) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(SAMPLES_PER_SYMBOL - 1);

  localparam logic [1:0] c_get_i = 2'd0;
  localparam logic [1:0] c_get_q = 2'd1;
  localparam logic [1:0] c_full  = 2'd2;

  logic [c_cnt_w-1:0] r_cnt;
  logic [1:0]         r_state;
  logic [6:0]         r_lfsr;
  logic               r_src_q;
  logic               r_stage_i;
  logic               r_stage_q;

  logic w_boundary;
  logic w_collecting;
  logic w_use_ext;
  logic w_take;
  logic w_bit;

  // The Q bit always comes from the source latched while collecting I.
  assign w_use_ext    = (r_state == c_get_i) ? src_sel : r_src_q;
  assign w_collecting = (r_state == c_get_i) || (r_state == c_get_q);
  assign w_boundary   = en && (r_cnt == c_last);
  assign w_take       = w_collecting && (w_use_ext ? ext.ext_valid : 1'b1);
  assign w_bit        = w_use_ext ? ext.ext_bit : r_lfsr[6];

  assign ext.ext_ready = ((r_state == c_get_i) && src_sel) ||
                         ((r_state == c_get_q) && r_src_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_state    <= c_get_i;
      r_lfsr     <= PRBS_SEED;
      r_src_q    <= 1'b0;
      r_stage_i  <= 1'b0;
      r_stage_q  <= 1'b0;
      elojel_sin <= 1'b0;
      elojel_cos <= 1'b0;
      sym_strobe <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      sym_strobe <= 1'b0;
      underrun   <= 1'b0;

      if (en) begin
        r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + c_cnt_w'(1);
      end

      if (w_take && !w_use_ext) begin
        r_lfsr <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
      end

      // A boundary with an incomplete pair keeps the old symbol and staging.
      if (w_boundary) begin
        if (r_state == c_full) begin
          elojel_sin <= r_stage_i;
          elojel_cos <= r_stage_q;
          sym_strobe <= 1'b1;
        end else begin
          underrun   <= 1'b1;
        end
      end

      case (r_state)
        c_get_i: begin
          r_src_q <= src_sel;
          if (w_take) begin
            r_stage_i <= w_bit;
            r_state   <= c_get_q;
          end
        end
        c_get_q: begin
          if (w_take) begin
            r_stage_q <= w_bit;
            r_state   <= c_full;
          end
        end
        c_full: begin
          if (w_boundary) begin
            r_state <= c_get_i;
          end
        end
        default: r_state <= c_get_i;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qam_symbol_source.sv
`default_nettype none
// ============================================================================
// Module      : tb_qam_symbol_source
// Description : Randomised and directed bench for qam_symbol_source against a
//               bit-count level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qam_symbol_source;

  localparam int         SPS  = 4;
  localparam logic [6:0] SEED = 7'h7F;

  logic clk;
  logic rst;
  logic en;
  logic src_sel;
  logic elojel_sin;
  logic elojel_cos;
  logic sym_strobe;
  logic underrun;

  qam_symbol_source_if ifc ();

  qam_symbol_source #(
    .SAMPLES_PER_SYMBOL (SPS),
    .PRBS_SEED          (SEED)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .src_sel    (src_sel),
    .ext        (ifc.slave),
    .elojel_sin (elojel_sin),
    .elojel_cos (elojel_cos),
    .sym_strobe (sym_strobe),
    .underrun   (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Reference model: PRBS as a precomputed bit sequence, staging as a bit count.
  bit prbs [127];
  int m_n;
  bit m_b0, m_b1, m_src;
  int m_pidx;
  int m_cnt;
  bit m_sin, m_cos, m_stb, m_und;
  bit m_took_ext;

  task automatic build_prbs();
    logic [6:0] seed_v;
    seed_v = SEED;
    for (int i = 0; i < 7; i++) prbs[i] = seed_v[6-i];
    for (int n = 7; n < 127; n++) prbs[n] = prbs[n-7] ^ prbs[n-6];
  endtask

  task automatic model_reset();
    m_n = 0; m_b0 = 0; m_b1 = 0; m_src = 0; m_pidx = 0; m_cnt = 0;
    m_sin = 0; m_cos = 0; m_stb = 0; m_und = 0; m_took_ext = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; ifc.ext_valid = 1'b0; ifc.ext_bit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic step(input bit a_en, input bit a_sel, input bit a_bit, input bit a_valid);
    bit use_ext, rdy, bnd, take, bv;
    en = a_en; src_sel = a_sel; ifc.ext_bit = a_bit; ifc.ext_valid = a_valid;
    #1;
    use_ext = (m_n == 0) ? a_sel : m_src;
    rdy     = (m_n < 2) && use_ext;
    total++;
    if (ifc.ext_ready !== rdy) begin
      bad++;
      $display("FAIL ext_ready t=%0t got=%b exp=%b", $time, ifc.ext_ready, rdy);
    end
    @(posedge clk);
    bnd  = a_en && (m_cnt == SPS - 1);
    take = (m_n < 2) && (use_ext ? a_valid : 1'b1);
    bv   = use_ext ? a_bit : prbs[m_pidx % 127];
    m_stb = 0; m_und = 0; m_took_ext = 0;
    if (bnd) begin
      if (m_n == 2) begin m_sin = m_b0; m_cos = m_b1; m_stb = 1; end
      else m_und = 1;
    end
    if (m_n == 0) m_src = a_sel;
    if (bnd && m_n == 2) m_n = 0;
    else if (take) begin
      if (m_n == 0) m_b0 = bv; else m_b1 = bv;
      m_n++;
      if (use_ext) m_took_ext = 1; else m_pidx++;
    end
    if (a_en) m_cnt = (m_cnt == SPS - 1) ? 0 : m_cnt + 1;
    #1;
    total += 4;
    if (elojel_sin !== m_sin) begin bad++; $display("FAIL elojel_sin t=%0t got=%b exp=%b", $time, elojel_sin, m_sin); end
    if (elojel_cos !== m_cos) begin bad++; $display("FAIL elojel_cos t=%0t got=%b exp=%b", $time, elojel_cos, m_cos); end
    if (sym_strobe !== m_stb) begin bad++; $display("FAIL sym_strobe t=%0t got=%b exp=%b", $time, sym_strobe, m_stb); end
    if (underrun !== m_und)   begin bad++; $display("FAIL underrun t=%0t got=%b exp=%b", $time, underrun, m_und); end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; src_sel = 1'b1; ifc.ext_valid = 1'b0; ifc.ext_bit = 1'b0;
    #2;
    total += 5;
    if (elojel_sin !== 1'b0) begin bad++; $display("FAIL rst_sin got=%b exp=0", elojel_sin); end
    if (elojel_cos !== 1'b0) begin bad++; $display("FAIL rst_cos got=%b exp=0", elojel_cos); end
    if (sym_strobe !== 1'b0) begin bad++; $display("FAIL rst_strobe got=%b exp=0", sym_strobe); end
    if (underrun !== 1'b0)   begin bad++; $display("FAIL rst_underrun got=%b exp=0", underrun); end
    if (ifc.ext_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_sel1 got=%b exp=1", ifc.ext_ready); end
    src_sel = 1'b0;
    #1;
    total++;
    if (ifc.ext_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_sel0 got=%b exp=0", ifc.ext_ready); end
    do_reset();
  endtask

  task automatic test_prbs();
    bit exp_i [4];
    bit exp_q [4];
    int k;
    exp_i = '{1, 1, 1, 1};
    exp_q = '{1, 1, 1, 0};
    k = 0;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (sym_strobe === 1'b1 && k < 4) begin
        total++;
        if (elojel_sin !== exp_i[k] || elojel_cos !== exp_q[k]) begin
          bad++;
          $display("FAIL prbs_sym%0d got=%b%b exp=%b%b", k, elojel_sin, elojel_cos, exp_i[k], exp_q[k]);
        end
        k++;
      end
    end
    total++;
    if (k != 4) begin bad++; $display("FAIL prbs_loads got=%0d exp=4", k); end
  endtask

  task automatic test_external();
    bit bits [4];
    bit exp_i [2];
    bit exp_q [2];
    int idx, k;
    bits  = '{0, 1, 1, 0};
    exp_i = '{0, 1};
    exp_q = '{1, 0};
    idx = 0; k = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      step(1'b1, 1'b1, (idx < 4) ? bits[idx] : 1'b0, idx < 4);
      if (m_took_ext) idx++;
      if (sym_strobe === 1'b1 && k < 2) begin
        total++;
        if (elojel_sin !== exp_i[k] || elojel_cos !== exp_q[k]) begin
          bad++;
          $display("FAIL ext_sym%0d got=%b%b exp=%b%b", k, elojel_sin, elojel_cos, exp_i[k], exp_q[k]);
        end
        k++;
      end
    end
    total++;
    if (k != 2) begin bad++; $display("FAIL ext_loads got=%0d exp=2", k); end
  endtask

  task automatic test_ext_underrun();
    int und, stb;
    und = 0; stb = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0);
      if (underrun === 1'b1) und++;
      if (sym_strobe === 1'b1) stb++;
    end
    total += 2;
    if (und != 3) begin bad++; $display("FAIL ext_underrun_count got=%0d exp=3", und); end
    if (stb != 0) begin bad++; $display("FAIL ext_underrun_strobes got=%0d exp=0", stb); end
  endtask

  task automatic test_partial();
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0);
    total++;
    if (sym_strobe !== 1'b1 || elojel_sin !== 1'b1 || elojel_cos !== 1'b0) begin
      bad++;
      $display("FAIL partial_load got=%b%b%b exp=110", sym_strobe, elojel_sin, elojel_cos);
    end
  endtask

  task automatic test_switch();
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0);
    total++;
    if (m_pidx != 2) begin bad++; $display("FAIL switch_prbs_bits got=%0d exp=2", m_pidx); end
    repeat (8) step(1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    total += 4;
    if (elojel_sin !== 1'b0) begin bad++; $display("FAIL async_sin got=%b exp=0", elojel_sin); end
    if (elojel_cos !== 1'b0) begin bad++; $display("FAIL async_cos got=%b exp=0", elojel_cos); end
    if (sym_strobe !== 1'b0) begin bad++; $display("FAIL async_strobe got=%b exp=0", sym_strobe); end
    if (underrun !== 1'b0)   begin bad++; $display("FAIL async_underrun got=%b exp=0", underrun); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if (sym_strobe !== 1'b1 || elojel_sin !== 1'b1 || elojel_cos !== 1'b1) begin
      bad++;
      $display("FAIL restart_load got=%b%b%b exp=111", sym_strobe, elojel_sin, elojel_cos);
    end
  endtask

  task automatic test_random();
    bit sel;
    sel = 1'b0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 15) == 0) sel = ~sel;
      step($urandom_range(0, 3) != 0, sel, 1'($urandom), $urandom_range(0, 2) != 0);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    build_prbs();
    model_reset();
    test_reset();
    test_prbs();
    test_external();
    test_ext_underrun();
    test_partial();
    test_switch();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/qam_symbol_source.md
# qam_symbol_source

- Upstream symbol source for the QAM transmitter.
- Gets the bit stream from one of two sources: an internal PRBS-7 generator, or an external serial stream with a valid/ready handshake.
- Packs bits in pairs: first bit of a pair → I sign `elojel_sin`, second bit → Q sign `elojel_cos`.
- Holds each symbol stable for `SAMPLES_PER_SYMBOL` sample strobes, counted on the `en_clk` strobe from `main_cntr`; the held pair drives the mixer's `data_in`.

## Interface
Parameters:
- `SAMPLES_PER_SYMBOL`, default 64: number of `en` pulses per symbol; must be ≥1.
- `PRBS_SEED`, default 7'h7F: initial LFSR state; must be nonzero.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `en`, in, 1: sample-rate strobe, one `clk` wide (from `main_cntr`).
- `src_sel`, in, 1: 0 = internal PRBS, 1 = external serial input.
- `ext_bit`, in, 1: external serial data bit.
- `ext_valid`, in, 1: `ext_bit` is valid.
- `ext_ready`, out, 1: block will accept `ext_bit` this cycle.
- `elojel_sin`, out, 1: registered I sign bit of the current symbol.
- `elojel_cos`, out, 1: registered Q sign bit of the current symbol.
- `sym_strobe`, out, 1: one-cycle pulse, high in the cycle after a new symbol is loaded.
- `underrun`, out, 1: one-cycle pulse, high when a symbol boundary found no complete symbol.

## Operation
Symbol counter
- `cnt`: width max(1, clog2(`SAMPLES_PER_SYMBOL`)); reset value 0.
- Increments on `en`; wraps to 0 on `en` && `cnt`==`SAMPLES_PER_SYMBOL`-1.
- `boundary` = `en` && `cnt`==`SAMPLES_PER_SYMBOL`-1.

Collector FSM (reset state GET_I)
- GET_I:
  - Latch `src_q` <= `src_sel`.
  - On bit acceptance: `stage_i` <= bit, go to GET_Q.
- GET_Q:
  - On bit acceptance: `stage_q` <= bit, go to FULL.
- FULL:
  - Accept nothing; wait for `boundary`.
- Source used for acceptance: GET_I uses `src_sel`; GET_Q uses `src_q`. Both bits of a symbol therefore come from the same source; `src_sel` changes take effect only at the next GET_I.

Bit acceptance
- Internal source: one bit per `clk` in GET_I/GET_Q.
  - PRBS-7, polynomial x^7+x^6+1.
  - Output bit = `lfsr[6]`.
  - On each taken bit: `lfsr` <= {`lfsr[5:0]`, `lfsr[6]`^`lfsr[5]`}.
  - `lfsr` advances only when a bit is taken.
- External source: `ext_ready` = (state GET_I && `src_sel`) || (state GET_Q && `src_q`). This is combinational from registered state and `src_sel`, with no path from `ext_valid`.
  - A bit transfers on `ext_valid` && `ext_ready`.
  - `ext_bit` is ignored otherwise.

Symbol load
- On `boundary` with state FULL:
  - `elojel_sin` <= `stage_i`, `elojel_cos` <= `stage_q`.
  - `sym_strobe` <= 1.
  - State <= GET_I.
- On `boundary` with state GET_I or GET_Q:
  - `underrun` <= 1.
  - Outputs hold the previous symbol.
  - Partial staging is kept and collection continues.
- Otherwise `sym_strobe` and `underrun` <= 0.

Reset
- Async reset sets: `elojel_sin`=0, `elojel_cos`=0, `sym_strobe`=0, `underrun`=0, `cnt`=0, state GET_I, `lfsr`=`PRBS_SEED`, `src_q`=0, `stage_i`=0, `stage_q`=0.
- `ext_ready` follows state, so during and after reset it equals `src_sel`.
- Reset mid-symbol discards staged bits, with no `underrun` pulse.

## Timing
- Internal source reaches FULL 2 `clk` after entering GET_I.
- First symbol is loaded at the edge of the `SAMPLES_PER_SYMBOL`-th `en` pulse after reset; `sym_strobe` is high the following cycle.
- Outputs change only on load edges; they are stable for exactly `SAMPLES_PER_SYMBOL` `en` pulses when there is no underrun.
- Boundary and bit acceptance in the same cycle cannot occur in FULL; in GET_I/GET_Q the acceptance proceeds and the underrun is still flagged.
- With `SAMPLES_PER_SYMBOL`=1 and `en` high every cycle, the internal source produces `underrun` on two of every three boundaries. This is legal, documented behaviour.

## Test plan
- **PRBS sequence:** reset with `PRBS_SEED`=7'h7F, `src_sel`=0, `SAMPLES_PER_SYMBOL`=4, `en` every cycle → (`elojel_sin`,`elojel_cos`) sequence is (1,1),(1,1),(1,1),(1,0). Each pair is held 4 cycles, one `sym_strobe` per load, `underrun` never.
- **External stream:** `src_sel`=1, bits 0,1,1,0 presented with `ext_valid` held high → symbols (0,1) then (1,0). `ext_ready` is low while in FULL, so exactly 2 bits transfer per symbol.
- **External underrun:** `src_sel`=1, `ext_valid`=0 throughout → `underrun` pulses at every boundary, outputs stay 0, `sym_strobe` never asserts.
- **Partial symbol at boundary:** supply one bit, then the boundary, then the second bit → `underrun` at the first boundary. At the next boundary the pair (first, second) loads with `sym_strobe`.
- **Source switch mid-symbol:** `src_sel` toggled 0→1 while in GET_Q → the Q bit still comes from the PRBS and `ext_ready` stays 0; the next symbol uses the external source.
- **Reset mid-operation:** assert `rst` mid-symbol → all outputs are 0 immediately (asynchronously). After release, the first load occurs after `SAMPLES_PER_SYMBOL` `en` pulses and restarts the PRBS from `PRBS_SEED`.
